msj_pid_multichannel: RTL and testbench

Time-multiplexed, parametrised PID controller for the MSJ platform, the successor to the single-channel PD controller. One shared multiply/accumulate datapath serves NUM_CHANNELS motors in a sequential sweep. Each rising edge of update_controller triggers one sweep. Per-channel gains, limits and mode live in an internal register bank written over a simple config port from the HPS bridge; per-channel duty outputs feed the motor PWM blocks.

---
 rtl/msj_pid_multichannel.sv | 174 +++++++++++++++++
 tb/tb_msj_pid_multichannel.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/msj_pid_multichannel.sv
// msj_pid_multichannel: time-multiplexed PID controller sweeping NUM_CHANNELS motors through one shared datapath
module msj_pid_multichannel #(
    parameter int NUM_CHANNELS = 4,
    parameter int W            = 32,
    parameter int DUTY_OFFSET  = 50
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      update_controller,
    input  logic [NUM_CHANNELS*W-1:0] position,
    input  logic [NUM_CHANNELS*W-1:0] velocity,
    input  logic                      cfg_write,
    input  logic [3:0]                cfg_channel,
    input  logic [3:0]                cfg_reg,
    input  logic [W-1:0]              cfg_data,
    output logic [NUM_CHANNELS*W-1:0] duty,
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_dropped
);
    localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;

    typedef enum logic [2:0] {IDLE, ERR, MUL, SUM, CLAMP} state_t;

    state_t                state;
    logic [CW-1:0]         ch;
    logic                  upd_q;
    logic signed [W-1:0]   kp [NUM_CHANNELS];
    logic signed [W-1:0]   ki [NUM_CHANNELS];
    logic signed [W-1:0]   kd [NUM_CHANNELS];
    logic signed [W-1:0]   sp [NUM_CHANNELS];
    logic signed [W-1:0]   pos_max [NUM_CHANNELS];
    logic signed [W-1:0]   neg_max [NUM_CHANNELS];
    logic signed [W-1:0]   dead_band [NUM_CHANNELS];
    logic signed [W-1:0]   int_max [NUM_CHANNELS];
    logic signed [W-1:0]   integral [NUM_CHANNELS];
    logic signed [W-1:0]   last_err [NUM_CHANNELS];
    logic [4:0]            shift [NUM_CHANNELS];
    logic [1:0]            mode [NUM_CHANNELS];
    logic [W-1:0]          duty_q [NUM_CHANNELS];
    logic signed [W-1:0]   err_r, diff_r;
    logic                  zero_r;
    logic signed [2*W-1:0] p_r, i_r, d_r;
    logic signed [2*W+1:0] sum_r;
    logic signed [W-1:0]   meas, err_c, isat, integ_c, res_c;
    logic signed [W:0]     isum, imax;
    logic signed [2*W+1:0] sum_c, pmax, nmax;
    logic                  db_c, cfg_ok;

    function automatic logic signed [2*W-1:0] sx(input logic signed [W-1:0] x);
        return {{W{x[W-1]}}, x};
    endfunction

    // Shared datapath for the channel currently selected by the sweep
    always_comb begin
        meas    = mode[ch][0] ? $signed(velocity[int'(ch)*W +: W]) : $signed(position[int'(ch)*W +: W]);
        err_c   = sp[ch] - meas;
        db_c    = (err_c > -dead_band[ch]) && (err_c < dead_band[ch]);
        isum    = $signed({integral[ch][W-1], integral[ch]}) + $signed({err_c[W-1], err_c});
        imax    = $signed({int_max[ch][W-1], int_max[ch]});
        isat    = isum > imax ? int_max[ch] : (isum < -imax ? -int_max[ch] : isum[W-1:0]);
        integ_c = mode[ch][1] ? '0 : (db_c ? integral[ch] : isat);
        sum_c   = $signed({{2{p_r[2*W-1]}}, p_r}) + $signed({{2{i_r[2*W-1]}}, i_r}) + $signed({{2{d_r[2*W-1]}}, d_r});
        pmax    = $signed({{(W+2){pos_max[ch][W-1]}}, pos_max[ch]});
        nmax    = $signed({{(W+2){neg_max[ch][W-1]}}, neg_max[ch]});
        res_c   = (sum_r > pmax || nmax > pmax) ? pos_max[ch] : (sum_r < nmax ? neg_max[ch] : sum_r[W-1:0]);
        cfg_ok  = int'(cfg_channel) < NUM_CHANNELS;
    end

    // Unpack per-channel duty registers onto the output bus
    always_comb begin
        duty = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) duty[c*W +: W] = duty_q[c];
    end

    // Config register bank; writes are only accepted between sweeps
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                kp[c]        <= '0;
                ki[c]        <= '0;
                kd[c]        <= '0;
                sp[c]        <= '0;
                pos_max[c]   <= '0;
                neg_max[c]   <= '0;
                dead_band[c] <= '0;
                int_max[c]   <= '0;
                shift[c]     <= '0;
                mode[c]      <= 2'd2;
            end
            cfg_dropped <= 1'b0;
        end else if (cfg_write) begin
            if (busy) cfg_dropped <= 1'b1;
            else if (cfg_ok) begin
                case (cfg_reg)
                    4'd0: kp[cfg_channel[CW-1:0]]        <= cfg_data;
                    4'd1: ki[cfg_channel[CW-1:0]]        <= cfg_data;
                    4'd2: kd[cfg_channel[CW-1:0]]        <= cfg_data;
                    4'd3: sp[cfg_channel[CW-1:0]]        <= cfg_data;
                    4'd4: pos_max[cfg_channel[CW-1:0]]   <= cfg_data;
                    4'd5: neg_max[cfg_channel[CW-1:0]]   <= cfg_data;
                    4'd6: dead_band[cfg_channel[CW-1:0]] <= cfg_data;
                    4'd7: int_max[cfg_channel[CW-1:0]]   <= cfg_data;
                    4'd8: shift[cfg_channel[CW-1:0]]     <= cfg_data[4:0];
                    4'd9: mode[cfg_channel[CW-1:0]]      <= cfg_data[1:0];
                    default: ;
                endcase
            end
        end
    end

    // Sweep sequencer: four pipeline stages per channel, duty committed in CLAMP
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ch     <= '0;
            upd_q  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err_r  <= '0;
            diff_r <= '0;
            zero_r <= 1'b0;
            p_r    <= '0;
            i_r    <= '0;
            d_r    <= '0;
            sum_r  <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                integral[c] <= '0;
                last_err[c] <= '0;
                duty_q[c]   <= W'(DUTY_OFFSET);
            end
        end else begin
            upd_q <= update_controller;
            done  <= 1'b0;
            case (state)
                IDLE: if (update_controller && !upd_q) begin
                    state <= ERR;
                    ch    <= '0;
                    busy  <= 1'b1;
                end
                ERR: begin
                    err_r        <= err_c;
                    diff_r       <= err_c - last_err[ch];
                    zero_r       <= mode[ch][1] | db_c;
                    integral[ch] <= integ_c;
                    last_err[ch] <= mode[ch][1] ? '0 : err_c;
                    state        <= MUL;
                end
                MUL: begin
                    p_r   <= sx(kp[ch]) * sx(err_r);
                    i_r   <= sx(ki[ch]) * sx(integral[ch]);
                    d_r   <= sx(kd[ch]) * sx(diff_r);
                    state <= SUM;
                end
                SUM: begin
                    sum_r <= sum_c >>> shift[ch];
                    state <= CLAMP;
                end
                CLAMP: begin
                    duty_q[ch] <= W'(DUTY_OFFSET) - (zero_r ? '0 : res_c);
                    if (int'(ch) == NUM_CHANNELS - 1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        ch    <= ch + 1'b1;
                        state <= ERR;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_msj_pid_multichannel.sv
// tb_msj_pid_multichannel: directed stimulus against a sweep-timeline PID model, checked every cycle
module tb_msj_pid_multichannel;
    localparam int N   = 4;
    localparam int W   = 32;
    localparam int OFS = 50;

    logic         clock = 0, reset = 1, update_controller = 0, cfg_write = 0;
    logic [3:0]   cfg_channel = 0, cfg_reg = 0;
    logic [W-1:0] cfg_data = 0;
    logic [N*W-1:0] position, velocity, duty;
    logic         busy, done, cfg_dropped;
    logic signed [W-1:0] pos_in [N];
    logic signed [W-1:0] vel_in [N];
    int tests = 0, fails = 0;

    logic signed [W-1:0] m_kp [N], m_ki [N], m_kd [N], m_sp [N], m_pmax [N], m_nmax [N];
    logic signed [W-1:0] m_db [N], m_imax [N], m_int [N], m_last [N], m_res [N], m_duty [N];
    int   m_shift [N], m_mode [N];
    logic m_busy, m_done, m_drop, m_prev, m_edge;
    int   m_t;

    msj_pid_multichannel #(.NUM_CHANNELS(N), .W(W), .DUTY_OFFSET(OFS)) dut (
        .clock(clock), .reset(reset), .update_controller(update_controller),
        .position(position), .velocity(velocity),
        .cfg_write(cfg_write), .cfg_channel(cfg_channel), .cfg_reg(cfg_reg), .cfg_data(cfg_data),
        .duty(duty), .busy(busy), .done(done), .cfg_dropped(cfg_dropped)
    );

    always #5 clock = ~clock;

    always_comb begin
        for (int c = 0; c < N; c++) begin
            position[c*W +: W] = pos_in[c];
            velocity[c*W +: W] = vel_in[c];
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    function automatic void m_reset();
        for (int c = 0; c < N; c++) begin
            m_kp[c] = 0; m_ki[c] = 0; m_kd[c] = 0; m_sp[c] = 0; m_pmax[c] = 0; m_nmax[c] = 0;
            m_db[c] = 0; m_imax[c] = 0; m_int[c] = 0; m_last[c] = 0; m_res[c] = 0;
            m_duty[c] = OFS; m_shift[c] = 0; m_mode[c] = 2;
        end
        m_busy = 0; m_done = 0; m_drop = 0; m_prev = 0; m_t = 0;
    endfunction

    function automatic void m_cfg(input int c, input int r, input logic [W-1:0] d);
        case (r)
            0: m_kp[c] = d;
            1: m_ki[c] = d;
            2: m_kd[c] = d;
            3: m_sp[c] = d;
            4: m_pmax[c] = d;
            5: m_nmax[c] = d;
            6: m_db[c] = d;
            7: m_imax[c] = d;
            8: m_shift[c] = int'(d[4:0]);
            9: m_mode[c] = int'(d[1:0]);
            default: ;
        endcase
    endfunction

    // Plain-arithmetic PID step for one channel using the current measurement
    function automatic logic signed [W-1:0] pid(input int c);
        logic signed [W-1:0] err, de;
        longint ni;
        logic signed [65:0] p, i, d, s;
        err = m_sp[c] - (m_mode[c] == 1 ? vel_in[c] : pos_in[c]);
        if (m_mode[c] >= 2) begin
            m_int[c] = 0;
            m_last[c] = 0;
            return 0;
        end
        if (err > -m_db[c] && err < m_db[c]) begin
            m_last[c] = err;
            return 0;
        end
        ni = longint'(m_int[c]) + longint'(err);
        if (ni > longint'(m_imax[c])) ni = longint'(m_imax[c]);
        else if (ni < -longint'(m_imax[c])) ni = -longint'(m_imax[c]);
        m_int[c] = W'(ni);
        de = err - m_last[c];
        p = 66'(m_kp[c]) * 66'(err);
        i = 66'(m_ki[c]) * 66'(m_int[c]);
        d = 66'(m_kd[c]) * 66'(de);
        s = (p + i + d) >>> m_shift[c];
        m_last[c] = err;
        if (s > 66'(m_pmax[c]) || m_nmax[c] > m_pmax[c]) return m_pmax[c];
        if (s < 66'(m_nmax[c])) return m_nmax[c];
        return W'(s);
    endfunction

    // Model timeline: channel c sampled 4c+1 edges after the start edge, duty committed at 4c+4
    always @(posedge clock or posedge reset) begin
        if (reset) m_reset();
        else begin
            m_edge = update_controller && !m_prev;
            m_prev = update_controller;
            m_done = 0;
            if (cfg_write) begin
                if (m_busy) m_drop = 1;
                else if (cfg_channel < N) m_cfg(int'(cfg_channel), int'(cfg_reg), cfg_data);
            end
            if (m_busy) begin
                m_t++;
                if (m_t % 4 == 1) m_res[(m_t-1)/4] = pid((m_t-1)/4);
                if (m_t % 4 == 0) m_duty[m_t/4-1] = OFS - m_res[m_t/4-1];
                if (m_t == 4*N) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (m_edge) begin
                m_busy = 1;
                m_t = 0;
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clock) begin
        for (int c = 0; c < N; c++) check($sformatf("duty%0d", c), duty[c*W +: W], m_duty[c]);
        check("busy", W'(busy), W'(m_busy));
        check("done", W'(done), W'(m_done));
        check("cfg_dropped", W'(cfg_dropped), W'(m_drop));
    end

    task automatic cfg(input int c, input int r, input int d);
        cfg_channel = 4'(c);
        cfg_reg = 4'(r);
        cfg_data = W'(d);
        cfg_write = 1;
        @(negedge clock);
        cfg_write = 0;
    endtask

    task automatic sweep(output int done_at, output int nbusy);
        update_controller = 1;
        done_at = -1;
        nbusy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            update_controller = 0;
            if (busy) nbusy++;
            if (done) begin
                done_at = i;
                break;
            end
        end
        tests++;
        if (done_at < 0) begin
            fails++;
            $display("FAIL sweep_timeout: got no done within 100 cycles, expected done");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int da, nb, nd;
        int e1 [4] = '{40, 30, 25, 25};
        for (int c = 0; c < N; c++) begin
            pos_in[c] = 0;
            vel_in[c] = 0;
        end
        repeat (3) @(negedge clock);
        reset = 0;
        @(negedge clock);
        check("reset_duty0", duty[0 +: W], 50);
        check("reset_busy", W'(busy), 0);
        check("reset_done", W'(done), 0);
        check("reset_dropped", W'(cfg_dropped), 0);

        sweep(da, nb);
        check("done_latency", W'(da), 16);
        check("busy_cycles", W'(nb), 16);
        check("default_duty3", duty[3*W +: W], 50);
        @(negedge clock);

        cfg(0, 9, 0); cfg(0, 0, 2); cfg(0, 3, 100); cfg(0, 4, 1000); cfg(0, 5, -1000);
        pos_in[0] = 90;
        sweep(da, nb);
        check("ch0_p_only", duty[0 +: W], 30);
        cfg(0, 2, 3);
        sweep(da, nb);
        check("ch0_d_zero", duty[0 +: W], 30);

        cfg(1, 1, 1); cfg(1, 7, 25); cfg(1, 9, 1); cfg(1, 3, 10); cfg(1, 4, 1000); cfg(1, 5, -1000);
        vel_in[1] = 0;
        pos_in[1] = 77;
        for (int s = 0; s < 4; s++) begin
            sweep(da, nb);
            check($sformatf("ch1_integral_sweep%0d", s), duty[1*W +: W], W'(e1[s]));
        end

        cfg(2, 9, 0); cfg(2, 6, 5); cfg(2, 3, 100); cfg(2, 0, 1); cfg(2, 1, 1);
        cfg(2, 7, 100); cfg(2, 4, 1000); cfg(2, 5, -1000);
        pos_in[2] = 96;
        sweep(da, nb);
        check("ch2_deadband", duty[2*W +: W], 50);
        cfg(2, 6, 0); cfg(2, 0, 0);
        sweep(da, nb);
        check("ch2_integral_held", duty[2*W +: W], 46);
        cfg(2, 1, 0); cfg(2, 0, 1000); cfg(2, 4, 20);
        sweep(da, nb);
        check("ch2_pos_clamp", duty[2*W +: W], 30);
        cfg(2, 0, 8); cfg(2, 8, 3); cfg(2, 4, 1000);
        pos_in[2] = 90;
        sweep(da, nb);
        check("ch2_shift", duty[2*W +: W], 40);

        cfg(3, 9, 0); cfg(3, 0, 1); cfg(3, 3, 1); cfg(3, 4, 5); cfg(3, 5, 10);
        cfg(5, 0, 123);
        sweep(da, nb);
        check("ch3_upper_wins", duty[3*W +: W], 45);
        cfg(3, 5, -7); cfg(3, 3, -100);
        sweep(da, nb);
        check("ch3_neg_clamp", duty[3*W +: W], 57);

        update_controller = 1;
        @(negedge clock);
        update_controller = 0;
        repeat (4) @(negedge clock);
        update_controller = 1;
        cfg_channel = 0; cfg_reg = 0; cfg_data = 99; cfg_write = 1;
        @(negedge clock);
        update_controller = 0;
        cfg_write = 0;
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) nd++;
            @(negedge clock);
        end
        check("done_pulses_busy_edge", W'(nd), 1);
        check("dropped_set", W'(cfg_dropped), 1);
        sweep(da, nb);
        check("kp_unchanged_duty0", duty[0 +: W], 30);
        check("dropped_sticky", W'(cfg_dropped), 1);
        @(negedge clock);

        update_controller = 1;
        @(negedge clock);
        update_controller = 0;
        repeat (5) @(negedge clock);
        #2 reset = 1;
        #1;
        check("abort_busy", W'(busy), 0);
        check("abort_duty0", duty[0 +: W], 50);
        check("abort_duty2", duty[2*W +: W], 50);
        check("abort_dropped", W'(cfg_dropped), 0);
        @(negedge clock);
        #2 reset = 0;
        nd = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clock);
            if (done) nd++;
        end
        check("no_done_after_abort", W'(nd), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
